// File: rtl/ttm_regbank_if.sv
// ttm_regbank_if: strobe, bus and register-output signals between the decoder/ALU side and the TTM4 register bank
interface ttm_regbank_if #(
  parameter int DW = 4,
  parameter int NJ = 2,
  parameter int NO = 2,
  parameter int NI = 2
);
  logic [DW-1:0]    storebus;
  logic [NJ-1:0]    njr_st;
  logic [NO-1:0]    nor_st;
  logic [NJ-1:0]    njr_out;
  logic [NI-1:0]    nir_out;
  logic             npc_ld;
  logic             npc_inc;
  logic [DW*NI-1:0] ir;
  logic [DW-1:0]    loadbus;
  logic             loadbus_oe;
  logic             bus_err;
  logic [DW*NJ-1:0] pa;
  logic             pc_co;
  logic [DW*NO-1:0] oreg;
  modport master (
    output storebus, njr_st, nor_st, njr_out, nir_out, npc_ld, npc_inc, ir,
    input  loadbus, loadbus_oe, bus_err, pa, pc_co, oreg
  );
  modport slave (
    input  storebus, njr_st, nor_st, njr_out, nir_out, npc_ld, npc_inc, ir,
    output loadbus, loadbus_oe, bus_err, pa, pc_co, oreg
  );
endinterface

// File: rtl/ttm_regbank.sv
// ttm_regbank: nibble-sliced JR/OR/IR registers, 74HC161-style PC and a single muxed LOADBUS with sticky contention flag
module ttm_regbank #(
  parameter int DW = 4,
  parameter int NJ = 2,
  parameter int NO = 2,
  parameter int NI = 2
) (
  input logic clk,
  input logic rst_n,
  ttm_regbank_if.slave bus
);
  localparam int PW = DW * NJ;
  localparam int SW = NJ + NI;
  logic [NJ-1:0][DW-1:0] jr;
  logic [NO-1:0][DW-1:0] oreg;
  logic [PW-1:0]         pc;
  logic [DW*NI-1:0]      ir_s1, ir_s2;
  logic                  bus_err;
  logic [SW-1:0]         sel;
  logic                  one_hot;
  logic [DW-1:0]         mux;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jr      <= '0;
      oreg    <= '0;
      pc      <= '0;
      ir_s1   <= '0;
      ir_s2   <= '0;
      bus_err <= 1'b0;
    end else begin
      for (int j = 0; j < NJ; j++) if (!bus.njr_st[j]) jr[j] <= bus.storebus;
      for (int o = 0; o < NO; o++) if (!bus.nor_st[o]) oreg[o] <= bus.storebus;
      ir_s1 <= bus.ir;
      ir_s2 <= ir_s1;
      pc    <= !bus.npc_ld ? jr : !bus.npc_inc ? pc + PW'(1) : pc;
      if (|sel && !one_hot) bus_err <= 1'b1;
    end
  end
  // JR selects occupy the low bits of sel, IR selects the high bits
  always_comb begin
    sel     = ~{bus.nir_out, bus.njr_out};
    one_hot = (sel != '0) && ((sel & (sel - SW'(1))) == '0);
    mux     = '0;
    for (int j = 0; j < NJ; j++) mux = mux | (sel[j] ? jr[j] : '0);
    for (int i = 0; i < NI; i++) mux = mux | (sel[NJ+i] ? ir_s2[i*DW +: DW] : '0);
  end
  assign bus.loadbus    = one_hot ? mux : '0;
  assign bus.loadbus_oe = one_hot;
  assign bus.bus_err    = bus_err;
  assign bus.pa         = pc;
  assign bus.pc_co      = &pc && !bus.npc_inc && bus.npc_ld;
  assign bus.oreg       = oreg;
endmodule

// File: tb/tb_ttm_regbank.sv
// tb_ttm_regbank: directed stimulus pushes expected values into a queue; a negedge monitor pops and compares them
module tb_ttm_regbank;
  localparam int DW = 4, NJ = 2, NO = 2, NI = 2;
  typedef enum int {K_PA, K_LB, K_OE, K_ERR, K_CO, K_OR} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] val;
    string       name;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  ttm_regbank_if #(.DW(DW), .NJ(NJ), .NO(NO), .NI(NI)) b ();
  ttm_regbank #(.DW(DW), .NJ(NJ), .NO(NO), .NI(NI)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  function automatic logic [31:0] actual(kind_t k);
    case (k)
      K_PA:    return 32'(b.pa);
      K_LB:    return 32'(b.loadbus);
      K_OE:    return 32'(b.loadbus_oe);
      K_ERR:   return 32'(b.bus_err);
      K_CO:    return 32'(b.pc_co);
      default: return 32'(b.oreg);
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
      end
    end
  end
  task automatic expect_val(kind_t k, logic [31:0] v, string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    q.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    b.storebus = '0; b.njr_st = '1; b.nor_st = '1; b.njr_out = '1; b.nir_out = '1;
    b.npc_ld = 1'b1; b.npc_inc = 1'b1; b.ir = '0;
    expect_val(K_PA, 0, "rst_pa");
    expect_val(K_LB, 0, "rst_lb");
    expect_val(K_OE, 0, "rst_oe");
    expect_val(K_ERR, 0, "rst_err");
    expect_val(K_CO, 0, "rst_co");
    expect_val(K_OR, 0, "rst_or");
    @(negedge clk);
    #1;
    cyc();
    rst_n = 1'b1;
    // JR load then PC load from JR
    b.storebus = 4'hA; b.njr_st = 2'b10; cyc();
    b.storebus = 4'h5; b.njr_st = 2'b01; cyc();
    b.njr_st = 2'b11; b.npc_ld = 1'b0; cyc();
    b.npc_ld = 1'b0 ^ 1'b1; b.njr_out = 2'b10;
    expect_val(K_PA, 32'h5A, "pc_load");
    expect_val(K_LB, 32'hA, "jr0_read");
    expect_val(K_OE, 1, "jr0_oe");
    cyc();
    b.njr_out = 2'b11;
    // PC wrap through 0xFF
    b.storebus = 4'hE; b.njr_st = 2'b10; cyc();
    b.storebus = 4'hF; b.njr_st = 2'b01; cyc();
    b.njr_st = 2'b11; b.npc_ld = 1'b0; cyc();
    b.npc_ld = 1'b1; b.npc_inc = 1'b0;
    expect_val(K_PA, 32'hFE, "pc_fe");
    expect_val(K_CO, 0, "co_fe");
    cyc();
    expect_val(K_PA, 32'hFF, "pc_ff");
    expect_val(K_CO, 1, "co_ff");
    cyc();
    expect_val(K_PA, 32'h00, "pc_wrap");
    expect_val(K_CO, 0, "co_wrap");
    cyc();
    b.npc_inc = 1'b1;
    expect_val(K_PA, 32'h01, "pc_01");
    cyc();
    // same-cycle store and read returns the old nibble
    b.storebus = 4'hC; b.njr_st = 2'b10; cyc();
    b.storebus = 4'h3; b.njr_out = 2'b10;
    expect_val(K_LB, 32'hC, "rd_old");
    cyc();
    b.njr_st = 2'b11;
    expect_val(K_LB, 32'h3, "rd_new");
    cyc();
    b.njr_out = 2'b11;
    // OR nibbles, then both strobes together
    b.storebus = 4'h7; b.nor_st = 2'b01; cyc();
    b.storebus = 4'h2; b.nor_st = 2'b10; cyc();
    b.nor_st = 2'b11;
    expect_val(K_OR, 32'h72, "or_72");
    cyc();
    b.storebus = 4'hB; b.nor_st = 2'b00; cyc();
    b.nor_st = 2'b11;
    expect_val(K_OR, 32'hBB, "or_bb");
    cyc();
    // IR two-stage synchroniser
    b.ir = 8'h96; cyc();
    b.nir_out = 2'b01;
    expect_val(K_LB, 32'h0, "ir_edge1");
    expect_val(K_OE, 1, "ir_oe");
    cyc();
    expect_val(K_LB, 32'h9, "ir_edge2");
    cyc();
    // contention: JR0 and IR1 together
    b.njr_out = 2'b10; b.nir_out = 2'b01;
    expect_val(K_LB, 0, "cont_lb");
    expect_val(K_OE, 0, "cont_oe");
    expect_val(K_ERR, 0, "cont_err_pre");
    cyc();
    b.njr_out = 2'b11; b.nir_out = 2'b11;
    expect_val(K_ERR, 1, "cont_err_set");
    for (int i = 0; i < 10; i++) cyc();
    expect_val(K_ERR, 1, "cont_err_sticky");
    cyc();
    // load beats increment
    b.storebus = 4'h0; b.njr_st = 2'b10; cyc();
    b.storebus = 4'h1; b.njr_st = 2'b01; cyc();
    b.njr_st = 2'b11; b.npc_ld = 1'b0; cyc();
    b.npc_ld = 1'b1; b.storebus = 4'h0; b.njr_st = 2'b10; cyc();
    b.storebus = 4'h4; b.njr_st = 2'b01; cyc();
    b.njr_st = 2'b11; b.npc_ld = 1'b0; b.npc_inc = 1'b0;
    expect_val(K_PA, 32'h10, "pc_10");
    cyc();
    b.npc_ld = 1'b1;
    expect_val(K_PA, 32'h40, "ld_over_inc");
    cyc();
    expect_val(K_PA, 32'h41, "pc_41");
    cyc();
    // asynchronous reset mid-count, checked before any further edge
    rst_n = 1'b0;
    expect_val(K_PA, 0, "async_pa");
    expect_val(K_ERR, 0, "async_err");
    expect_val(K_OR, 0, "async_or");
    cyc();
    rst_n = 1'b1; b.npc_inc = 1'b1;
    cyc();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d expected 0", q.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
